// File: rtl/cpu_mem_responder.sv
// RAM-port responder for SimpleCPU: registered one-cycle reads, byte-stream program loader.
// Optional MMIO window (IO_OUT / IO_IN / CYCLES) at the top three addresses when CPU_MEM_MMIO_EN is defined.
module cpu_mem_responder #(
    parameter int SIZE = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wrEn,
    input  logic [SIZE-1:0] addr_toRAM,
    input  logic [31:0]     data_toRAM,
    output logic [31:0]     data_fromRAM,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [7:0]      ld_byte,
    input  logic            ld_last,
    output logic            ld_done,
    output logic            cpu_hold,
    input  logic [31:0]     io_in,
    output logic [31:0]     io_out
);

    // state   | meaning
    // ST_RUN  | CPU owns the RAM port, loader stalled
    // ST_LOAD | loader fills RAM from address 0, CPU held in reset
    typedef enum logic {ST_RUN, ST_LOAD} state_t;

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [SIZE-1:0] waddr_q, waddr_d;
    logic [31:0]     asm_q, asm_d;
    logic            done_q, done_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [31:0]     mem [2**SIZE];

    logic            accept;
    logic            word_full;
    logic [31:0]     asm_next;
    logic            mmio_hit;
    logic            ram_we;
    logic [SIZE-1:0] ram_waddr;
    logic [31:0]     ram_wdata;

    assign accept    = (state_q == ST_LOAD) && ld_valid;
    assign asm_next  = asm_q | ({24'd0, ld_byte} << {cnt_q, 3'b000});
    assign word_full = accept && ((cnt_q == 2'd3) || ld_last);

    assign ld_ready     = (state_q == ST_LOAD);
    assign cpu_hold     = (state_q == ST_LOAD);
    assign ld_done      = done_q;
    assign data_fromRAM = cpu_hold ? 32'd0 : rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        asm_d   = asm_q;
        done_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ld_valid) begin
                    state_d = ST_LOAD;
                    cnt_d   = 2'd0;
                    waddr_d = '0;
                    asm_d   = 32'd0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (word_full) begin
                        cnt_d   = 2'd0;
                        asm_d   = 32'd0;
                        waddr_d = waddr_q + SIZE'(1);
                        if (ld_last) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                        asm_d = asm_next;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

`ifdef CPU_MEM_MMIO_EN
    localparam logic [SIZE-1:0] A_OUT = {SIZE{1'b1}};
    localparam logic [SIZE-1:0] A_IN  = A_OUT - SIZE'(1);
    localparam logic [SIZE-1:0] A_CYC = A_OUT - SIZE'(2);

    logic [31:0] io_out_q;
    logic [31:0] cycles_q;

    assign mmio_hit = (addr_toRAM >= A_CYC);
    assign io_out   = io_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            io_out_q <= 32'd0;
            cycles_q <= 32'd0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
            if ((state_q == ST_RUN) && wrEn && (addr_toRAM == A_OUT))
                io_out_q <= data_toRAM;
        end
    end
`else
    logic unused_io;

    assign mmio_hit  = 1'b0;
    assign io_out    = 32'd0;
    assign unused_io = ^io_in;
`endif

    always_comb begin
        rdata_d = 32'd0;
        if (state_q == ST_RUN) begin
            rdata_d = mem[addr_toRAM];
`ifdef CPU_MEM_MMIO_EN
            if (addr_toRAM == A_OUT)      rdata_d = io_out_q;
            else if (addr_toRAM == A_IN)  rdata_d = io_in;
            else if (addr_toRAM == A_CYC) rdata_d = cycles_q;
`endif
        end
    end

    // Loader owns the write port in LOAD; CPU writes to the MMIO window never reach RAM.
    always_comb begin
        if (state_q == ST_LOAD) begin
            ram_we    = word_full && !rst;
            ram_waddr = waddr_q;
            ram_wdata = asm_next;
        end else begin
            ram_we    = wrEn && !mmio_hit && !rst;
            ram_waddr = addr_toRAM;
            ram_wdata = data_toRAM;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
            waddr_q <= '0;
            asm_q   <= 32'd0;
            done_q  <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            asm_q   <= asm_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed self-checking bench for cpu_mem_responder: CPU read/write, loader framing, reset, wrap, MMIO.
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wrEn = 1'b0;
    logic [9:0]  addr_toRAM = 10'd0;
    logic [31:0] data_toRAM = 32'd0;
    logic [31:0] data_fromRAM;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [7:0]  ld_byte = 8'd0;
    logic        ld_last = 1'b0;
    logic        ld_done;
    logic        cpu_hold;
    logic [31:0] io_in = 32'h1357_9BDF;
    logic [31:0] io_out;

    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          done_base;
    bit          hold_chk = 1'b0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    cpu_mem_responder #(.SIZE(10)) dut (
        .clk(clk), .rst(rst), .wrEn(wrEn), .addr_toRAM(addr_toRAM),
        .data_toRAM(data_toRAM), .data_fromRAM(data_fromRAM),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_byte(ld_byte),
        .ld_last(ld_last), .ld_done(ld_done), .cpu_hold(cpu_hold),
        .io_in(io_in), .io_out(io_out)
    );

    always @(negedge clk) if (ld_done === 1'b1) done_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One CPU cycle; when chk is set, the expected read data goes through the scoreboard.
    task automatic cpu_op(input logic we, input logic [9:0] a, input logic [31:0] d,
                          input bit chk, input logic [31:0] exp, input string tag);
        wrEn = we; addr_toRAM = a; data_toRAM = d;
        if (chk) exp_q.push_back(exp);
        @(posedge clk); #1;
        wrEn = 1'b0;
        if (chk) check(tag, data_fromRAM, exp_q.pop_front());
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        ld_valid = 1'b1; ld_byte = b; ld_last = last;
        while (ld_ready !== 1'b1 && n < 10) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 10) check("ld_ready_wait", 32'(ld_ready), 32'd1);
        if (hold_chk) check("cpu_hold_load", 32'(cpu_hold), 32'd1);
        @(posedge clk); #1;
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            send_byte(b, last && (i == 3));
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return {16'hC0DE, 16'(i)};
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_data", data_fromRAM, 32'd0);
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_done", 32'(ld_done), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_io_out", io_out, 32'd0);

        cpu_op(1'b1, 10'd5, 32'h1234_5678, 1'b0, 32'd0, "");
        cpu_op(1'b0, 10'd5, 32'd0, 1'b1, 32'h1234_5678, "wr_rd_5");

        cpu_op(1'b1, 10'd7, 32'h55, 1'b0, 32'd0, "");
        cpu_op(1'b1, 10'd7, 32'hAA, 1'b1, 32'h55, "read_first_old");
        cpu_op(1'b0, 10'd7, 32'd0, 1'b1, 32'hAA, "read_first_new");

        done_base = done_cnt;
        hold_chk = 1'b1;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        hold_chk = 1'b0;
        check("full_done_pulse", 32'(ld_done), 32'd1);
        check("full_hold_off", 32'(cpu_hold), 32'd0);
        @(posedge clk); #1;
        check("full_done_clear", 32'(ld_done), 32'd0);
        check("full_done_count", 32'(done_cnt - done_base), 32'd1);
        cpu_op(1'b0, 10'd0, 32'd0, 1'b1, 32'h0403_0201, "full_mem0");
        cpu_op(1'b0, 10'd1, 32'd0, 1'b1, 32'h0807_0605, "full_mem1");

        done_base = done_cnt;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_ready", 32'(ld_ready), 32'd0);
        check("rst_mid_hold", 32'(cpu_hold), 32'd0);
        @(posedge clk); #1;
        check("rst_mid_no_done", 32'(done_cnt - done_base), 32'd0);
        cpu_op(1'b0, 10'd0, 32'd0, 1'b1, 32'h0403_0201, "rst_mid_mem0");

        send_byte(8'h11, 1'b0);
        cpu_op(1'b1, 10'd5, 32'hBAD0_BAD0, 1'b1, 32'd0, "load_data_zero");
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        @(posedge clk); #1;
        cpu_op(1'b0, 10'd5, 32'd0, 1'b1, 32'h1234_5678, "load_wr_dropped");
        cpu_op(1'b0, 10'd0, 32'd0, 1'b1, 32'h4433_2211, "iso_mem0");

        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        send_byte(8'hEE, 1'b1);
        check("partial_done", 32'(ld_done), 32'd1);
        @(posedge clk); #1;
        cpu_op(1'b0, 10'd0, 32'd0, 1'b1, 32'h0403_0201, "partial_mem0");
        cpu_op(1'b0, 10'd1, 32'd0, 1'b1, 32'h0000_00EE, "partial_mem1");

        done_base = done_cnt;
        for (int i = 0; i < 1024; i++) send_word(pat(i), 1'b0);
        send_word(32'hDEAD_BEEF, 1'b1);
        @(posedge clk); #1;
        check("wrap_done_count", 32'(done_cnt - done_base), 32'd1);
        cpu_op(1'b0, 10'd0, 32'd0, 1'b1, 32'hDEAD_BEEF, "wrap_mem0");
        cpu_op(1'b0, 10'd1, 32'd0, 1'b1, pat(1), "wrap_mem1");
        cpu_op(1'b0, 10'd700, 32'd0, 1'b1, pat(700), "wrap_mem700");

`ifdef CPU_MEM_MMIO_EN
        begin
            logic [31:0] c1, c2;
            cpu_op(1'b1, 10'h3FF, 32'h0000_CAFE, 1'b0, 32'd0, "");
            check("mmio_io_out", io_out, 32'h0000_CAFE);
            cpu_op(1'b0, 10'h3FF, 32'd0, 1'b1, 32'h0000_CAFE, "mmio_rd_out");
            cpu_op(1'b0, 10'h3FE, 32'd0, 1'b1, 32'h1357_9BDF, "mmio_rd_in");
            addr_toRAM = 10'h3FD;
            @(posedge clk); #1;
            c1 = data_fromRAM;
            repeat (10) @(posedge clk);
            #1 c2 = data_fromRAM;
            check("mmio_cycles_delta", c2 - c1, 32'd10);
        end
`else
        cpu_op(1'b1, 10'h3FF, 32'h0000_CAFE, 1'b0, 32'd0, "");
        check("nommio_io_out", io_out, 32'd0);
        cpu_op(1'b0, 10'h3FF, 32'd0, 1'b1, 32'h0000_CAFE, "nommio_ram_3ff");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Memory-side responder for the SimpleCPU RAM port. It answers the CPU's `addr_toRAM` / `wrEn` / `data_toRAM` requests with registered one-cycle read data. It includes a byte-stream program loader that fills RAM while holding the CPU in reset, and optionally a small memory-mapped I/O window at the top of the address space.

## Interface
Parameters:
- `SIZE`, default 10: address width; RAM depth is 2^SIZE words of 32 bits.

Ports:
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `wrEn` in 1: CPU write enable.
- `addr_toRAM` in SIZE: CPU word address.
- `data_toRAM` in 32: CPU write data.
- `data_fromRAM` out 32: registered read data for the address presented the previous cycle.
- `ld_valid` in 1: loader byte valid.
- `ld_ready` out 1: loader byte accepted when `ld_valid & ld_ready`.
- `ld_byte` in 8: loader data byte.
- `ld_last` in 1: marks the final byte of the image; qualified by the handshake.
- `ld_done` out 1: one-cycle pulse after the final word is written.
- `cpu_hold` out 1: high while loading; the top level drives CPU reset from `rst | cpu_hold`.
- `io_in` in 32: external input port, read through MMIO.
- `io_out` out 32: external output register, written through MMIO.

## Operation
- **Two-state FSM.**
  - RUN: CPU port active, `ld_ready`=0.
  - LOAD: loader active, `ld_ready`=1, `cpu_hold`=1.
  - RUN → LOAD on the first cycle `ld_valid`=1; that byte is accepted in LOAD, not in RUN.
  - LOAD → RUN on the cycle the `ld_last` byte is accepted.
- **CPU read (RUN):** every cycle, `data_fromRAM <= mem[addr_toRAM]`, independent of `wrEn`.
- **CPU write (RUN):** when `wrEn`=1, `mem[addr_toRAM] <= data_toRAM`.
- **Read-during-write, same address:** `data_fromRAM` returns the old contents (read-first).
- **Loader framing:**
  - Bytes are little-endian into a 32-bit assembly register; byte counter 0..3, word address `waddr` starting at 0.
  - On the 4th byte, the full word is written to `mem[waddr]` and `waddr` increments.
  - `waddr` wraps from 2^SIZE-1 to 0.
- **Final byte with a partial word:** the word is written with unfilled upper bytes zero. The final write and the RUN transition happen on the same edge, and `ld_done` pulses the following cycle.
- **CPU port during LOAD:** ignored. `wrEn` writes are dropped and `data_fromRAM` is driven 0.
- **Counter handling:** byte counter, `waddr` and the assembly register clear on every RUN → LOAD entry. Each load therefore starts at address 0.

## Timing
- **Read latency:** exactly 1 cycle. The CPU drives the address in state N and samples `data_fromRAM` in state N+1.
- **Write latency:** the write takes effect at the edge where `wrEn`=1. A read of the same address issued the next cycle returns the new value.
- **Reset values:**
  - Outputs: `data_fromRAM`=0, `ld_ready`=0, `ld_done`=0, `cpu_hold`=0, `io_out`=0.
  - Internal: FSM=RUN, byte counter 0, `waddr` 0, cycle counter 0.
  - RAM contents are not cleared.
- **Reset mid-load:**
  - FSM returns to RUN and the partial word is discarded.
  - Words already written remain in RAM.
  - `ld_done` does not pulse.
- **Flow control:** `ld_valid` may drop mid-load; LOAD simply waits with `ld_ready`=1. There is no timeout.
- **`cpu_hold`:** combinational, equal to (state==LOAD).

## Configuration
- **Macro `CPU_MEM_MMIO_EN`.**
- **Defined:** the top three addresses are decoded as MMIO; the RAM words behind them stay loader-writable but CPU-invisible.
  - 2^SIZE-1 = IO_OUT: write updates `io_out`; read returns `io_out`.
  - 2^SIZE-2 = IO_IN: read returns `io_in` sampled at the read edge; writes ignored.
  - 2^SIZE-3 = CYCLES: free-running 32-bit counter, +1 every cycle, wraps at 2^32; writes ignored.
- **Not defined:**
  - All addresses are plain RAM.
  - `io_out` is tied to 0 and `io_in` is unused.
  - The cycle counter is not built.

## Test plan
- **CPU write/read:** `wrEn`=1, addr 5, data 0x12345678; next cycle addr 5, `wrEn`=0 → `data_fromRAM`=0x12345678 one cycle later.
- **Read-first:** same cycle `wrEn`=1, addr 7, data 0xAA, where mem[7]=0x55 → `data_fromRAM`=0x55; following read → 0xAA.
- **Full load:** bytes 01 02 03 04 05 06 07 08, `ld_last` on the 8th.
  - mem[0]=0x04030201, mem[1]=0x08070605.
  - `cpu_hold` is high from the first byte through the last.
  - `ld_done` pulses once, one cycle after the last accept.
- **Partial load and wrap:** 5 bytes with `ld_last` on the 5th → mem[1]=0x000000EE for byte 5 = 0xEE. With SIZE=2, loading 5 full words wraps and overwrites mem[0].
- **Reset and LOAD isolation:** `rst` after 2 bytes → state RUN, `ld_ready`=0, no `ld_done`, mem[0] unchanged. Separately, CPU `wrEn` during LOAD has no effect.
- **MMIO (`CPU_MEM_MMIO_EN`):**
  - Write 0xCAFE to 0x3FF → `io_out`=0xCAFE.
  - Two CYCLES reads 10 cycles apart differ by 10.
  - Without the macro, 0x3FF behaves as RAM.
